// File: rtl/i2c_slave.sv
// Single-address I2C target: oversampled SCL/SDA, START/STOP detection,
// ACKed multi-byte writes and fabric-fed multi-byte reads.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  state_t     state_r;
  logic [2:0] scl_sync_r;
  logic [2:0] sda_sync_r;
  logic [6:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic       phase_r;
  logic       rw_r;

  logic scl_rise_s;
  logic scl_fall_s;
  logic scl_high_s;
  logic sda_bit_s;
  logic start_det_s;
  logic stop_det_s;

  // Two synchronizer stages plus a "previous" stage per bus line; idle bus reads high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_r <= 3'b111;
      sda_sync_r <= 3'b111;
    end else begin
      scl_sync_r <= {scl_sync_r[1:0], scl};
      sda_sync_r <= {sda_sync_r[1:0], sda_in};
    end
  end

  assign scl_rise_s  = scl_sync_r[1] & ~scl_sync_r[2];
  assign scl_fall_s  = ~scl_sync_r[1] & scl_sync_r[2];
  assign scl_high_s  = scl_sync_r[1] & scl_sync_r[2];
  assign sda_bit_s   = sda_sync_r[1];
  assign start_det_s = scl_high_s & ~sda_sync_r[1] & sda_sync_r[2];
  assign stop_det_s  = scl_high_s & sda_sync_r[1] & ~sda_sync_r[2];

  // Protocol FSM; phase_r marks the second half of an ACK slot (or a received read ACK).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      shift_r   <= 7'h00;
      bit_cnt_r <= 3'd0;
      phase_r   <= 1'b0;
      rw_r      <= 1'b0;
      sda_oe    <= 1'b0;
      tx_req    <= 1'b0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      if (stop_det_s) begin
        state_r <= IDLE;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        phase_r <= 1'b0;
      end else if (start_det_s) begin
        state_r   <= ADDR;
        bit_cnt_r <= 3'd0;
        busy      <= 1'b0;
        sda_oe    <= 1'b0;
        phase_r   <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            sda_oe <= 1'b0;
          end
          ADDR: begin
            if (scl_rise_s) begin
              shift_r   <= {shift_r[5:0], sda_bit_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                // General call (address 0) is never claimed.
                if ((shift_r == SLAVE_ADDR) && (SLAVE_ADDR != 7'h00)) begin
                  state_r <= ADDR_ACK;
                  busy    <= 1'b1;
                  rw_r    <= sda_bit_s;
                  phase_r <= 1'b0;
                end else begin
                  state_r <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            if (scl_fall_s) begin
              if (!phase_r) begin
                sda_oe  <= 1'b1;
                phase_r <= 1'b1;
              end else begin
                phase_r   <= 1'b0;
                bit_cnt_r <= 3'd0;
                if ((state_r == ADDR_ACK) && rw_r) begin
                  shift_r <= tx_data[6:0];
                  tx_req  <= 1'b1;
                  sda_oe  <= ~tx_data[7];
                  state_r <= RD_DATA;
                end else begin
                  sda_oe  <= 1'b0;
                  state_r <= WR_DATA;
                end
              end
            end
          end
          WR_DATA: begin
            if (scl_rise_s) begin
              shift_r   <= {shift_r[5:0], sda_bit_s};
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                rx_data  <= {shift_r, sda_bit_s};
                rx_valid <= 1'b1;
                state_r  <= WR_ACK;
                phase_r  <= 1'b0;
              end
            end
          end
          RD_DATA: begin
            if (scl_rise_s) begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (bit_cnt_r == 3'd7) begin
                state_r <= RD_ACK;
                phase_r <= 1'b0;
              end
            end else if (scl_fall_s) begin
              sda_oe  <= ~shift_r[6];
              shift_r <= {shift_r[5:0], 1'b0};
            end
          end
          RD_ACK: begin
            if (scl_fall_s) begin
              if (phase_r) begin
                phase_r   <= 1'b0;
                bit_cnt_r <= 3'd0;
                shift_r   <= tx_data[6:0];
                tx_req    <= 1'b1;
                sda_oe    <= ~tx_data[7];
                state_r   <= RD_DATA;
              end else begin
                sda_oe <= 1'b0;
              end
            end else if (scl_rise_s) begin
              if (sda_bit_s) begin
                sda_oe  <= 1'b0;
                state_r <= WAIT_STOP;
              end else begin
                phase_r <= 1'b1;
              end
            end
          end
          WAIT_STOP: begin
            sda_oe <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
            sda_oe  <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench: bit-banged I2C master, table of directed transfers,
// randomized transfers against a transaction-level model, reset/restart corners.
module tb_i2c_slave;

  localparam int Q = 40;
  localparam int H = 80;

  typedef struct {
    logic [6:0]  addr;
    logic        rw;
    int          n;
    logic [31:0] data;       // first byte in bits 31:24
    logic        exp_ack;
    logic [31:0] exp_bytes;  // received bytes (write) or bus bytes (read)
    int          exp_pulses; // rx_valid (write) or tx_req (read) pulses
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl;
  logic       m_pull;
  logic       sda_bus;
  logic       sda_oe, tx_req, rx_valid, busy;
  logic [7:0] tx_data, rx_data;
  logic [7:0] tx_mem [8];
  logic [7:0] rx_log [$];

  int total = 0;
  int bad = 0;
  int rx_cnt = 0;
  int tx_cnt = 0;
  int both_cnt = 0;
  int oe_cycles = 0;

  always #5 clk = ~clk;

  assign sda_bus = ~(m_pull | sda_oe);
  assign tx_data = tx_mem[tx_cnt[2:0]];

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl      (scl),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt <= rx_cnt + 1;
      rx_log.push_back(rx_data);
    end
    if (tx_req) tx_cnt <= tx_cnt + 1;
    if (tx_req && rx_valid) both_cnt <= both_cnt + 1;
    if (sda_oe) oe_cycles <= oe_cycles + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clk_bit(input logic pull, output logic bus_v, output logic oe_v);
    m_pull = pull;
    #Q scl = 1'b1;
    #Q;
    bus_v = sda_bus;
    oe_v  = sda_oe;
    #Q scl = 1'b0;
    #Q;
  endtask

  task automatic start_cond();
    m_pull = 1'b0;
    #Q scl = 1'b1;
    #Q m_pull = 1'b1;
    #H scl = 1'b0;
    #Q;
  endtask

  task automatic stop_cond();
    m_pull = 1'b1;
    #Q scl = 1'b1;
    #Q m_pull = 1'b0;
    #H;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic bus_v, oe_v;
    for (int i = 7; i >= 0; i--) clk_bit(~b[i], bus_v, oe_v);
    clk_bit(1'b0, bus_v, oe_v);
    ack = ~bus_v;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic master_ack, output logic oe_ack);
    logic bus_v, oe_v;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b0, bus_v, oe_v);
      b[i] = bus_v;
    end
    clk_bit(master_ack, bus_v, oe_v);
    oe_ack = oe_v;
  endtask

  function automatic vec_t mk(input logic [6:0] a, input logic rw, input int n,
                              input logic [31:0] d, input logic ea,
                              input logic [31:0] e, input int p);
    vec_t v;
    v.addr = a; v.rw = rw; v.n = n; v.data = d;
    v.exp_ack = ea; v.exp_bytes = e; v.exp_pulses = p;
    return v;
  endfunction

  // Transaction-level reference: only the configured address is claimed.
  function automatic vec_t model(input logic [6:0] a, input logic rw, input int n,
                                 input logic [31:0] d);
    logic hit;
    hit = (a == 7'h50);
    return mk(a, rw, n, d, hit, (hit || !rw) ? d : 32'hFFFF_FFFF, hit ? n : 0);
  endfunction

  task automatic run_txn(input vec_t v);
    logic [7:0] b;
    logic       ack, oe_a;
    int         rx0, tx0, oe0, lb;
    rx0 = rx_cnt; tx0 = tx_cnt; oe0 = oe_cycles; lb = rx_log.size();
    for (int k = 0; k < 4; k++) tx_mem[(tx0 + k) % 8] = v.data[31 - 8*k -: 8];
    start_cond();
    send_byte({v.addr, v.rw}, ack);
    check("addr_ack", ack, v.exp_ack);
    check("busy_on", busy, v.exp_ack);
    for (int k = 0; k < v.n; k++) begin
      if (!v.rw) begin
        send_byte(v.data[31 - 8*k -: 8], ack);
        check("data_ack", ack, v.exp_ack);
      end else begin
        recv_byte(b, k < v.n - 1, oe_a);
        check("rd_byte", b, v.exp_bytes[31 - 8*k -: 8]);
        check("rd_ack_release", oe_a, 1'b0);
      end
    end
    stop_cond();
    repeat (4) @(negedge clk);
    check("busy_off", busy, 1'b0);
    check("oe_off", sda_oe, 1'b0);
    if (v.rw) check("tx_req_count", tx_cnt - tx0, v.exp_pulses);
    else      check("rx_valid_count", rx_cnt - rx0, v.exp_pulses);
    if (!v.rw)
      for (int k = 0; k < v.exp_pulses; k++)
        if (lb + k < rx_log.size())
          check("rx_data", rx_log[lb + k], v.exp_bytes[31 - 8*k -: 8]);
    if (!v.exp_ack) check("oe_quiet", oe_cycles - oe0, 0);
  endtask

  vec_t tbl [7];

  initial begin
    logic       ack, bus_v, oe_v;
    logic [7:0] addr_byte;
    int         rx0;
    vec_t       v;

    for (int i = 0; i < 8; i++) tx_mem[i] = 8'h00;
    reset = 1'b1; scl = 1'b1; m_pull = 1'b0;
    #20;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_tx_req", tx_req, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    #20 reset = 1'b0;
    #80;

    tbl[0] = mk(7'h50, 1'b0, 1, 32'hA500_0000, 1'b1, 32'hA500_0000, 1);
    tbl[1] = mk(7'h50, 1'b1, 1, 32'h3C00_0000, 1'b1, 32'h3C00_0000, 1);
    tbl[2] = mk(7'h51, 1'b0, 1, 32'hA200_0000, 1'b0, 32'hA200_0000, 0);
    tbl[3] = mk(7'h50, 1'b0, 2, 32'h1122_0000, 1'b1, 32'h1122_0000, 2);
    tbl[4] = mk(7'h50, 1'b1, 2, 32'h817E_0000, 1'b1, 32'h817E_0000, 2);
    tbl[5] = mk(7'h00, 1'b0, 1, 32'h3300_0000, 1'b0, 32'h3300_0000, 0);
    tbl[6] = mk(7'h28, 1'b1, 1, 32'h5500_0000, 1'b0, 32'hFF00_0000, 0);
    for (int i = 0; i < 7; i++) run_txn(tbl[i]);
    check("rx_hold", rx_data, 8'h22);

    // Reset asserted while the address ACK is being driven.
    rx0 = rx_cnt;
    start_cond();
    addr_byte = 8'hA0;
    for (int i = 7; i >= 0; i--) clk_bit(~addr_byte[i], bus_v, oe_v);
    m_pull = 1'b0;
    #Q scl = 1'b1;
    #Q;
    check("oe_before_reset", sda_oe, 1'b1);
    reset = 1'b1;
    #1;
    check("oe_async_reset", sda_oe, 1'b0);
    check("busy_async_reset", busy, 1'b0);
    #9 reset = 1'b0;
    #(Q - 10) scl = 1'b0;
    #Q;
    stop_cond();
    check("reset_no_rx", rx_cnt - rx0, 0);
    run_txn(mk(7'h50, 1'b0, 1, 32'h5A00_0000, 1'b1, 32'h5A00_0000, 1));

    // Repeated START after four data bits discards the partial byte.
    rx0 = rx_cnt;
    start_cond();
    send_byte(8'hA0, ack);
    check("rs_first_ack", ack, 1'b1);
    clk_bit(1'b0, bus_v, oe_v);
    clk_bit(1'b1, bus_v, oe_v);
    clk_bit(1'b0, bus_v, oe_v);
    clk_bit(1'b0, bus_v, oe_v);
    start_cond();
    check("rs_oe", sda_oe, 1'b0);
    check("rs_busy", busy, 1'b0);
    check("rs_no_rx", rx_cnt - rx0, 0);
    send_byte(8'hA0, ack);
    check("rs_addr_ack", ack, 1'b1);
    send_byte(8'hC3, ack);
    check("rs_data_ack", ack, 1'b1);
    stop_cond();
    repeat (4) @(negedge clk);
    check("rs_rx_count", rx_cnt - rx0, 1);
    check("rs_rx_data", rx_data, 8'hC3);

    for (int i = 0; i < 20; i++) begin
      logic [6:0] a;
      a = ($urandom_range(0, 1) == 0) ? 7'h50 : 7'($urandom_range(0, 127));
      v = model(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom());
      run_txn(v);
    end

    check("req_valid_overlap", both_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
